// File: rtl/cpu_pkg.sv
// Shared CPU constants and small address helpers used by the fetch front end.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~(32'h0000_0003);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with registered storage; head is read straight out of the storage registers.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    empty     = (count == CW'(0));
    full      = (count == CW'(DEPTH));
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    head_data = mem[rd_ptr];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit_chk.sv
// Invariant monitor for the fetch unit: credit accounting and FIFO overflow.
module ifetch_unit_chk #(
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   resp_push,
  input logic                   out_pop,
  input logic                   fifo_full,
  input logic                   issue,
  input logic                   pcq_full,
  input logic [$clog2(DEPTH):0] inflight,
  input logic [$clog2(DEPTH):0] discard,
  input logic [$clog2(DEPTH):0] pcq_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Sampled every active edge outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(resp_push && fifo_full && !out_pop));
      assert (!(issue && pcq_full));
      assert (inflight <= CW'(DEPTH));
      assert (discard <= CW'(DEPTH));
      assert (pcq_count == inflight);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order reads and buffers {pc,instr} for decode.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC_P = RESET_PC,
  parameter int                DEPTH      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               im_req,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic               im_gnt,
  input  logic               im_rvalid,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]          fetch_pc;
  logic [CW-1:0]              inflight;
  logic [CW-1:0]              discard;
  logic [CW-1:0]              inflight_next;
  logic [CW:0]                credit_used;
  logic                       issue;
  logic                       retire;
  logic                       drop;
  logic                       resp_push;
  logic                       out_pop;
  logic [ADDR_W+INSTR_W-1:0]  fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic [ADDR_W-1:0]          pcq_head;
  logic                       pcq_full;
  logic                       pcq_empty;
  logic [CW-1:0]              pcq_count;

  // Credit counts a head leaving this cycle as a free slot so a full pipe sustains one word per cycle.
  always_comb begin
    out_pop       = !fifo_empty && out_ready;
    credit_used   = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(out_pop);
    im_req        = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
    im_addr       = fetch_pc;
    issue         = im_req && im_gnt;
    retire        = im_rvalid && !pcq_empty;
    drop          = retire && (discard != CW'(0));
    resp_push     = retire && !drop && !redirect;
    inflight_next = inflight + CW'(issue) - CW'(retire);
  end

  // Fetch PC, outstanding-read and stale-response counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC_P;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        discard  <= inflight_next;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (drop) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + INSTR_W)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (resp_push),
    .push_data ({pcq_head, im_rdata}),
    .pop       (out_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Not flushed on redirect: stale responses still pop their recorded PCs.
  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (retire),
    .head_data (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_head[ADDR_W+INSTR_W-1:INSTR_W];
  assign out_instr = fifo_head[INSTR_W-1:0];

  ifetch_unit_chk #(.DEPTH(DEPTH)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .resp_push (resp_push),
    .out_pop   (out_pop),
    .fifo_full (fifo_full),
    .issue     (issue),
    .pcq_full  (pcq_full),
    .inflight  (inflight),
    .discard   (discard),
    .pcq_count (pcq_count)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: memory model returns words in order, decode side checks {pc,instr}.
module tb_ifetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pending[$];
  logic [63:0] exp_q[$];
  logic [31:0] iss_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] model_pc;
  bit          mem_on;
  bit          last_pop;

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_gnt      (im_gnt),
    .im_rvalid   (im_rvalid),
    .im_rdata    (im_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0101;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, answer memory after it.
  task automatic tick();
    logic [63:0] e;
    #1;
    last_pop = out_valid && out_ready;
    if (last_pop && !rst) begin
      pop_log.push_back(out_pc);
      if (exp_q.size() == 0) begin
        check_eq("pop_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_pc", out_pc, e[63:32]);
        check_eq("out_instr", out_instr, e[31:0]);
      end
    end
    if (im_req && im_gnt) begin
      check_eq("im_addr", im_addr, model_pc);
      pending.push_back(im_addr);
      exp_q.push_back({model_pc, word_of(model_pc)});
      iss_log.push_back(im_addr);
      model_pc = model_pc + 32'd4;
    end
    if (rst) begin
      exp_q.delete();
      pending.delete();
      model_pc = RESET_PC;
    end else if (redirect) begin
      exp_q.delete();
      model_pc = redirect_pc & ~32'h3;
    end
    @(posedge clk);
    #1;
    if (mem_on && pending.size() > 0) begin
      im_rvalid = 1'b1;
      im_rdata  = word_of(pending.pop_front());
    end else begin
      im_rvalid = 1'b0;
      im_rdata  = 32'h0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    im_gnt = 1'b0; out_ready = 1'b1; mem_on = 1'b1;
    repeat (8) tick();
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    im_gnt = 1'b1;
  endtask

  initial begin
    int pops;
    logic [31:0] held;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    im_gnt = 1'b1; out_ready = 1'b1; mem_on = 1'b1;
    im_rvalid = 1'b0; im_rdata = 32'h0; model_pc = RESET_PC;
    @(negedge clk);
    #1;
    check_eq("rst_im_req", 32'(im_req), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_im_addr", im_addr, 32'h0000_3000);
    check_eq("rst_im_req_after", 32'(im_req), 32'd1);

    // Streaming from reset, one instruction per cycle.
    iss_log.delete(); pop_log.delete(); pops = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i >= 5 && last_pop) pops++;
    end
    check_eq("t1_iss0", q_at(iss_log, 0), 32'h0000_3000);
    check_eq("t1_iss1", q_at(iss_log, 1), 32'h0000_3004);
    check_eq("t1_iss2", q_at(iss_log, 2), 32'h0000_3008);
    check_eq("t1_pop0", q_at(pop_log, 0), 32'h0000_3000);
    check_eq("t1_pop1", q_at(pop_log, 1), 32'h0000_3004);
    check_eq("t1_throughput", 32'(pops), 32'd20);

    // Redirect latency: new instruction visible three cycles later.
    redirect = 1'b1; redirect_pc = 32'h0000_5000;
    tick();
    redirect = 1'b0;
    #1 check_eq("lat_t1_valid", 32'(out_valid), 32'd0);
    tick();
    #1 check_eq("lat_t2_valid", 32'(out_valid), 32'd0);
    tick();
    #1 check_eq("lat_t3_valid", 32'(out_valid), 32'd1);
    check_eq("lat_t3_pc", out_pc, 32'h0000_5000);
    drain("lat_drain");

    // Back-pressure: only DEPTH reads may be issued.
    out_ready = 1'b0; iss_log.delete();
    repeat (10) tick();
    check_eq("t2_issued", 32'(iss_log.size()), 32'(DEPTH));
    #1 check_eq("t2_im_req", 32'(im_req), 32'd0);
    pop_log.delete();
    drain("t2_drain");
    check_eq("t2_popped", 32'(pop_log.size()), 32'(DEPTH));

    // Redirect with two reads outstanding; stale words must vanish.
    mem_on = 1'b0; out_ready = 1'b1; im_gnt = 1'b1;
    tick(); tick();
    im_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_4002;
    tick();
    redirect = 1'b0; mem_on = 1'b1; im_gnt = 1'b1; pop_log.delete();
    repeat (10) tick();
    check_eq("t3_pop0", q_at(pop_log, 0), 32'h0000_4000);
    check_eq("t3_pop1", q_at(pop_log, 1), 32'h0000_4004);
    drain("t3_drain");

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0; iss_log.delete();
    repeat (6) tick();
    check_eq("t4_iss0", q_at(iss_log, 0), 32'hFFFF_FFF8);
    check_eq("t4_iss1", q_at(iss_log, 1), 32'hFFFF_FFFC);
    check_eq("t4_iss2", q_at(iss_log, 2), 32'h0000_0000);
    drain("t4_drain");

    // Grant withheld: request and address hold steady.
    im_gnt = 1'b0; iss_log.delete();
    #1 held = im_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check_eq("t5_im_req", 32'(im_req), 32'd1);
      check_eq("t5_im_addr", im_addr, held);
    end
    check_eq("t5_no_issue", 32'(iss_log.size()), 32'd0);
    im_gnt = 1'b1;
    drain("t5_drain");

    // Reset with FIFO occupied, a read in flight and redirect asserted.
    out_ready = 1'b0; im_gnt = 1'b1; mem_on = 1'b1;
    repeat (4) tick();
    #1 check_eq("t6_full_valid", 32'(out_valid), 32'd1);
    check_eq("t6_full_req", 32'(im_req), 32'd0);
    mem_on = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_8000;
    tick();
    rst = 1'b0; redirect = 1'b0;
    #1;
    check_eq("t6_out_valid", 32'(out_valid), 32'd0);
    check_eq("t6_im_addr", im_addr, 32'h0000_3000);
    check_eq("t6_out_pc", out_pc, 32'h0);
    mem_on = 1'b1; out_ready = 1'b1; pop_log.delete();
    repeat (6) tick();
    check_eq("t6_pop0", q_at(pop_log, 0), 32'h0000_3000);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
